// File: rtl/cryptoprocessor_seq.sv
// cryptoprocessor_seq: self-sequencing front end for the external carry-save
// add/sub and multiply/reduce units. Commands are queued, then fetched one at
// a time; each one reads a carry/sum operand pair from the register file,
// runs on the matching unit and writes back or streams a value out.
module cryptoprocessor_seq #(
   parameter int W        = 89,
   parameter int ADDR_W   = 7,
   parameter int IQ_DEPTH = 8,
   parameter int ADD_LAT  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [3+3*ADDR_W-1:0]   command_cp,
   input  logic [W-1:0]            din_1,
   input  logic [W-1:0]            din_2,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic [W-1:0]            dout_1,
   output logic [W-1:0]            dout_2,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [W-1:0]            op_a_c,
   output logic [W-1:0]            op_a_s,
   output logic [W-1:0]            op_b_c,
   output logic [W-1:0]            op_b_s,
   input  logic [W-1:0]            add_o_c,
   input  logic [W-1:0]            add_o_s,
   input  logic [W-1:0]            sub_o_c,
   input  logic [W-1:0]            sub_o_s,
   input  logic [W-1:0]            red_o_c,
   input  logic [W-1:0]            red_o_s,
   output logic                    mul_start,
   input  logic                    mul_done,
   output logic                    busy,
   output logic                    ins_done,
   output logic                    err
);

   localparam int CMD_W = 3 + 3*ADDR_W;
   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(ADD_LAT + 1);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_MUL  = 3'd4,
      OP_COPY = 3'd5,
      OP_READ = 3'd6,
      OP_RSVD = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_EX,
      S_OUT
   } state_t;

   logic [CMD_W-1:0]  r_queue [IQ_DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;

   logic [W-1:0]      r_bankC [DEPTH];
   logic [W-1:0]      r_bankS [DEPTH];

   state_t            r_state;
   logic [CMD_W-1:0]  r_cmd;
   logic [W-1:0]      r_opAC;
   logic [W-1:0]      r_opAS;
   logic [W-1:0]      r_opBC;
   logic [W-1:0]      r_opBS;
   logic [LAT_W-1:0]  r_latCnt;
   logic              r_mulStart;
   logic              r_dinReady;
   logic              r_doutValid;
   logic              r_err;

   op_t               w_op;
   logic [ADDR_W-1:0] w_dst;
   logic [ADDR_W-1:0] w_srcA;
   logic [ADDR_W-1:0] w_srcB;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_retire;
   logic              w_wrEn;
   logic [W-1:0]      w_wrC;
   logic [W-1:0]      w_wrS;

   assign w_op    = op_t'(r_cmd[CMD_W-1 -: 3]);
   assign w_dst   = r_cmd[3*ADDR_W-1 -: ADDR_W];
   assign w_srcA  = r_cmd[2*ADDR_W-1 -: ADDR_W];
   assign w_srcB  = r_cmd[ADDR_W-1:0];

   // A push into a full queue is dropped even if a pop frees a slot this cycle
   assign w_full  = (r_count == CNT_W'(IQ_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = cmd_valid && !w_full;
   assign w_pop   = (r_state == S_IDLE) && !w_empty;

   // Retire condition per state; depends on live handshakes so it stays combinational
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_RD:  w_retire = (w_op == OP_NOP) || (w_op == OP_RSVD);
         S_EX: begin
            case (w_op)
               OP_ADD,
               OP_SUB:  w_retire = (r_latCnt == LAT_W'(1));
               OP_MUL:  w_retire = mul_done && !r_mulStart;
               OP_COPY: w_retire = 1'b1;
               OP_LOAD: w_retire = din_valid && r_dinReady;
               default: w_retire = 1'b0;
            endcase
         end
         S_OUT: w_retire = dout_ready;
         default: w_retire = 1'b0;
      endcase
   end

   // Write-back source selection; only EX retirements write the register file
   always_comb begin
      w_wrEn = 1'b0;
      w_wrC  = r_opAC;
      w_wrS  = r_opAS;
      if (r_state == S_EX && w_retire) begin
         case (w_op)
            OP_LOAD: begin w_wrEn = 1'b1; w_wrC = din_1;   w_wrS = din_2;   end
            OP_ADD:  begin w_wrEn = 1'b1; w_wrC = add_o_c; w_wrS = add_o_s; end
            OP_SUB:  begin w_wrEn = 1'b1; w_wrC = sub_o_c; w_wrS = sub_o_s; end
            OP_MUL:  begin w_wrEn = 1'b1; w_wrC = red_o_c; w_wrS = red_o_s; end
            OP_COPY: begin w_wrEn = 1'b1; w_wrC = r_opAC;  w_wrS = r_opAS;  end
            default: w_wrEn = 1'b0;
         endcase
      end
   end

   // Command queue storage; contents need no reset because the count gates them
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_queue[r_wrPtr] <= command_cp;
      end
   end

   // Command queue pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Register file: carry and sum banks written together, deliberately not reset
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_bankC[w_dst] <= w_wrC;
         r_bankS[w_dst] <= w_wrS;
      end
   end

   // Sequencer: fetch, operand read, execute, and read-out handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd       <= '0;
         r_opAC      <= '0;
         r_opAS      <= '0;
         r_opBC      <= '0;
         r_opBS      <= '0;
         r_latCnt    <= '0;
         r_mulStart  <= 1'b0;
         r_dinReady  <= 1'b0;
         r_doutValid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mulStart <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_cmd   <= r_queue[r_rdPtr];
                  r_state <= S_RD;
               end
            end
            S_RD: begin
               r_opAC <= r_bankC[w_srcA];
               r_opAS <= r_bankS[w_srcA];
               r_opBC <= r_bankC[w_srcB];
               r_opBS <= r_bankS[w_srcB];
               if (w_op == OP_NOP || w_op == OP_RSVD) begin
                  r_err   <= r_err | (w_op == OP_RSVD);
                  r_state <= S_IDLE;
               end else begin
                  r_state    <= S_EX;
                  r_latCnt   <= LAT_W'(ADD_LAT);
                  r_mulStart <= (w_op == OP_MUL);
                  r_dinReady <= (w_op == OP_LOAD);
               end
            end
            S_EX: begin
               if (w_op == OP_READ) begin
                  r_state     <= S_OUT;
                  r_doutValid <= 1'b1;
               end else if (w_retire) begin
                  r_state    <= S_IDLE;
                  r_dinReady <= 1'b0;
               end else if (w_op == OP_ADD || w_op == OP_SUB) begin
                  r_latCnt <= r_latCnt - LAT_W'(1);
               end
            end
            S_OUT: begin
               if (w_retire) begin
                  r_state     <= S_IDLE;
                  r_doutValid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = !w_full;
   assign din_ready  = r_dinReady;
   assign dout_valid = r_doutValid;
   assign dout_1     = r_doutValid ? r_opAC : '0;
   assign dout_2     = r_doutValid ? r_opAS : '0;
   assign op_a_c     = r_opAC;
   assign op_a_s     = r_opAS;
   assign op_b_c     = r_opBC;
   assign op_b_s     = r_opBS;
   assign mul_start  = r_mulStart;
   assign busy       = !w_empty || (r_state != S_IDLE);
   assign ins_done   = w_retire;
   assign err        = r_err;

endmodule

// File: tb/tb_cryptoprocessor_seq.sv
// tb_cryptoprocessor_seq: directed checks of cryptoprocessor_seq with hand-
// computed retire cycles and data. A main instance uses ADD_LAT=3 at default
// widths; a second, narrow instance (W=16, ADDR_W=4) exercises the 15-bit
// command format.
module tb_cryptoprocessor_seq;

   localparam int W   = 89;
   localparam int AW  = 7;
   localparam int CW  = 3 + 3*AW;
   localparam int SW  = 16;
   localparam int SAW = 4;
   localparam int SCW = 3 + 3*SAW;

   logic          clk = 1'b0;
   logic          rst;

   logic          cmd_valid, cmd_ready, din_valid, din_ready;
   logic [CW-1:0] command_cp;
   logic [W-1:0]  din_1, din_2, dout_1, dout_2;
   logic          dout_valid, dout_ready;
   logic [W-1:0]  op_a_c, op_a_s, op_b_c, op_b_s;
   logic [W-1:0]  add_o_c, add_o_s, sub_o_c, sub_o_s, red_o_c, red_o_s;
   logic          mul_start, mul_done, busy, ins_done, err;

   logic           s_cmd_valid, s_cmd_ready, s_din_valid, s_din_ready;
   logic [SCW-1:0] s_command;
   logic [SW-1:0]  s_din_1, s_din_2, s_dout_1, s_dout_2;
   logic           s_dout_valid, s_dout_ready;
   logic [SW-1:0]  s_op_a_c, s_op_a_s, s_op_b_c, s_op_b_s;
   logic [SW-1:0]  s_add_c, s_add_s, s_sub_c, s_sub_s, s_red_c, s_red_s;
   logic           s_mul_start, s_mul_done, s_busy, s_ins_done, s_err;

   int cyc = 0;
   int doneLog[$];
   int mulLog[$];
   int nCompared = 0;
   int nMismatched = 0;
   int b;
   int b2;
   logic readyLog [9];
   logic [W-1:0] bigRed;

   cryptoprocessor_seq #(.W(W), .ADDR_W(AW), .IQ_DEPTH(8), .ADD_LAT(3)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .command_cp(command_cp),
      .din_1(din_1), .din_2(din_2), .din_valid(din_valid), .din_ready(din_ready),
      .dout_1(dout_1), .dout_2(dout_2), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .op_a_c(op_a_c), .op_a_s(op_a_s), .op_b_c(op_b_c), .op_b_s(op_b_s),
      .add_o_c(add_o_c), .add_o_s(add_o_s), .sub_o_c(sub_o_c), .sub_o_s(sub_o_s),
      .red_o_c(red_o_c), .red_o_s(red_o_s),
      .mul_start(mul_start), .mul_done(mul_done),
      .busy(busy), .ins_done(ins_done), .err(err)
   );

   cryptoprocessor_seq #(.W(SW), .ADDR_W(SAW), .IQ_DEPTH(4), .ADD_LAT(1)) u_dutSmall (
      .clk(clk), .rst(rst),
      .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .command_cp(s_command),
      .din_1(s_din_1), .din_2(s_din_2), .din_valid(s_din_valid), .din_ready(s_din_ready),
      .dout_1(s_dout_1), .dout_2(s_dout_2), .dout_valid(s_dout_valid), .dout_ready(s_dout_ready),
      .op_a_c(s_op_a_c), .op_a_s(s_op_a_s), .op_b_c(s_op_b_c), .op_b_s(s_op_b_s),
      .add_o_c(s_add_c), .add_o_s(s_add_s), .sub_o_c(s_sub_c), .sub_o_s(s_sub_s),
      .red_o_c(s_red_c), .red_o_s(s_red_s),
      .mul_start(s_mul_start), .mul_done(s_mul_done),
      .busy(s_busy), .ins_done(s_ins_done), .err(s_err)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Cycle index, advanced at every rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Record the cycle of every retirement and multiply launch of the main instance
   always @(negedge clk) begin
      if (ins_done)  doneLog.push_back(cyc);
      if (mul_start) mulLog.push_back(cyc);
   end

   // Hard stop in case the sequence never reaches its end
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkNextDone(input string tag, input int exp);
      if (doneLog.size() == 0) checkOutput(tag, '1, exp);
      else                     checkOutput(tag, doneLog.pop_front(), exp);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) nextCycle();
   endtask

   task automatic applyStimulus(input logic [CW-1:0] cmd);
      cmd_valid  = 1'b1;
      command_cp = cmd;
      nextCycle();
      cmd_valid  = 1'b0;
   endtask

   task automatic applySmall(input logic [SCW-1:0] cmd);
      s_cmd_valid = 1'b1;
      s_command   = cmd;
      nextCycle();
      s_cmd_valid = 1'b0;
   endtask

   function automatic logic [CW-1:0] mkCmd(input logic [2:0] op, input int dst, input int sa, input int sb);
      return {op, AW'(dst), AW'(sa), AW'(sb)};
   endfunction

   function automatic logic [SCW-1:0] mkSmall(input logic [2:0] op, input int dst, input int sa, input int sb);
      return {op, SAW'(dst), SAW'(sa), SAW'(sb)};
   endfunction

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; command_cp = '0;
      din_valid = 1'b0; din_1 = '0; din_2 = '0; dout_ready = 1'b0;
      add_o_c = W'(32'hA); add_o_s = W'(32'hB);
      sub_o_c = W'(32'h33); sub_o_s = W'(32'h44);
      red_o_c = W'(32'h55); red_o_s = W'(32'h66);
      mul_done = 1'b0;
      s_cmd_valid = 1'b0; s_command = '0;
      s_din_valid = 1'b0; s_din_1 = '0; s_din_2 = '0; s_dout_ready = 1'b0;
      s_add_c = 16'h00AA; s_add_s = 16'h00BB; s_sub_c = 16'h0011; s_sub_s = 16'h0022;
      s_red_c = '0; s_red_s = '0; s_mul_done = 1'b0;
      bigRed = 89'h1_2345_6789_ABCD_EF01_2345;

      // Reset values
      nextCycle();
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst cmd_ready", cmd_ready, 1);
      checkOutput("rst din_ready", din_ready, 0);
      checkOutput("rst dout_valid", dout_valid, 0);
      checkOutput("rst dout_1", dout_1, 0);
      checkOutput("rst dout_2", dout_2, 0);
      checkOutput("rst op_a_c", op_a_c, 0);
      checkOutput("rst op_b_s", op_b_s, 0);
      checkOutput("rst mul_start", mul_start, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst ins_done", ins_done, 0);
      checkOutput("rst err", err, 0);

      // LOAD r5 <- (1,2), then READ r5 with a stalled consumer
      nextCycle();
      b = cyc;
      applyStimulus(mkCmd(3'd1, 5, 0, 0));
      applyStimulus(mkCmd(3'd6, 0, 5, 0));
      waitUntil(b + 3);
      @(negedge clk);
      checkOutput("load din_ready", din_ready, 1);
      waitUntil(b + 5);
      din_valid = 1'b1; din_1 = W'(32'h1); din_2 = W'(32'h2);
      nextCycle();
      din_valid = 1'b0; din_1 = '0; din_2 = '0;
      waitUntil(b + 8);
      @(negedge clk);
      checkOutput("read valid early", dout_valid, 0);
      waitUntil(b + 11);
      @(negedge clk);
      checkOutput("read held valid", dout_valid, 1);
      checkOutput("read r5 carry", dout_1, 1);
      checkOutput("read r5 sum", dout_2, 2);
      waitUntil(b + 12);
      dout_ready = 1'b1;
      nextCycle();
      dout_ready = 1'b0;
      @(negedge clk);
      checkOutput("read valid drop", dout_valid, 0);
      checkOutput("read dout zero", dout_1, 0);
      checkNextDone("load retire", b + 5);
      checkNextDone("read retire", b + 12);

      // NOP, ADD r7 <- add_o, COPY r8 <- r7, then read both back
      nextCycle();
      b = cyc;
      applyStimulus(mkCmd(3'd0, 0, 0, 0));
      applyStimulus(mkCmd(3'd2, 7, 5, 5));
      applyStimulus(mkCmd(3'd5, 8, 7, 0));
      waitUntil(b + 5);
      @(negedge clk);
      checkOutput("add op_a_c", op_a_c, 1);
      checkOutput("add op_b_s", op_b_s, 2);
      waitUntil(b + 8);
      add_o_c = W'(32'hC); add_o_s = W'(32'hD);
      dout_ready = 1'b1;
      waitUntil(b + 11);
      applyStimulus(mkCmd(3'd6, 0, 7, 0));
      applyStimulus(mkCmd(3'd6, 0, 8, 0));
      waitUntil(b + 15);
      @(negedge clk);
      checkOutput("r7 carry", dout_1, 32'hA);
      checkOutput("r7 sum", dout_2, 32'hB);
      waitUntil(b + 19);
      @(negedge clk);
      checkOutput("r8 carry", dout_1, 32'hA);
      checkOutput("r8 sum", dout_2, 32'hB);
      nextCycle();
      dout_ready = 1'b0;
      checkNextDone("nop retire", b + 2);
      checkNextDone("add retire", b + 7);
      checkNextDone("copy retire", b + 10);
      checkNextDone("read r7 retire", b + 15);
      checkNextDone("read r8 retire", b + 19);

      // Stray mul_done while idle, then MUL r9 with a 20-cycle multiplier
      nextCycle();
      b = cyc;
      mul_done = 1'b1;
      nextCycle();
      mul_done = 1'b0;
      waitUntil(b + 3);
      checkOutput("stray mul_done", doneLog.size(), 0);
      b2 = cyc;
      applyStimulus(mkCmd(3'd4, 9, 5, 7));
      waitUntil(b2 + 10);
      @(negedge clk);
      checkOutput("mul op_b_c", op_b_c, 32'hA);
      checkOutput("mul op_a_s", op_a_s, 2);
      waitUntil(b2 + 23);
      mul_done = 1'b1; red_o_c = bigRed; red_o_s = W'(32'h42);
      nextCycle();
      mul_done = 1'b0; red_o_c = W'(32'h55); red_o_s = W'(32'h66);
      dout_ready = 1'b1;
      applyStimulus(mkCmd(3'd6, 0, 9, 0));
      waitUntil(b2 + 28);
      @(negedge clk);
      checkOutput("r9 carry", dout_1, bigRed);
      checkOutput("r9 sum", dout_2, 32'h42);
      nextCycle();
      dout_ready = 1'b0;
      checkOutput("mul_start pulses", mulLog.size(), 1);
      if (mulLog.size() > 0) checkOutput("mul_start cycle", mulLog[0], b2 + 3);
      checkNextDone("mul retire", b2 + 23);
      checkNextDone("read r9 retire", b2 + 28);

      // Fill the queue behind a stalled LOAD; the ninth push is dropped
      nextCycle();
      b = cyc;
      applyStimulus(mkCmd(3'd1, 10, 0, 0));
      waitUntil(b + 4);
      for (int i = 0; i < 9; i++) begin
         cmd_valid  = 1'b1;
         command_cp = mkCmd(3'd0, 0, 0, 0);
         @(negedge clk);
         readyLog[i] = cmd_ready;
         nextCycle();
      end
      cmd_valid = 1'b0;
      checkOutput("ready before 8th", readyLog[7], 1);
      checkOutput("ready at 9th", readyLog[8], 0);
      @(negedge clk);
      checkOutput("full busy", busy, 1);
      waitUntil(b + 14);
      din_valid = 1'b1; din_1 = W'(32'h77); din_2 = W'(32'h88);
      nextCycle();
      din_valid = 1'b0;
      waitUntil(b + 40);
      @(negedge clk);
      checkOutput("drained busy", busy, 0);
      checkNextDone("stall load retire", b + 14);
      for (int k = 0; k < 8; k++) checkNextDone("queued nop retire", b + 16 + 2*k);
      checkOutput("no 9th retire", doneLog.size(), 0);

      // Reset during ADD EX aborts it and empties the queue
      nextCycle();
      b = cyc;
      applyStimulus(mkCmd(3'd2, 5, 7, 7));
      applyStimulus(mkCmd(3'd0, 0, 0, 0));
      waitUntil(b + 4);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid rst busy", busy, 0);
      checkOutput("mid rst cmd_ready", cmd_ready, 1);
      checkOutput("mid rst op_a_c", op_a_c, 0);
      checkOutput("mid rst ins_done", ins_done, 0);
      nextCycle();
      rst = 1'b0;
      waitUntil(b + 8);
      @(negedge clk);
      checkOutput("post rst busy", busy, 0);
      checkOutput("post rst retires", doneLog.size(), 0);
      nextCycle();
      b2 = cyc;
      dout_ready = 1'b1;
      applyStimulus(mkCmd(3'd6, 0, 5, 0));
      waitUntil(b2 + 4);
      @(negedge clk);
      checkOutput("r5 kept carry", dout_1, 1);
      checkOutput("r5 kept sum", dout_2, 2);
      nextCycle();
      dout_ready = 1'b0;
      checkNextDone("post rst read", b2 + 4);

      // Reserved op: retires at t+1, sets sticky err, leaves r5 untouched
      nextCycle();
      b = cyc;
      applyStimulus(mkCmd(3'd7, 5, 7, 7));
      applyStimulus(mkCmd(3'd0, 0, 0, 0));
      waitUntil(b + 2);
      @(negedge clk);
      checkOutput("err before", err, 0);
      waitUntil(b + 3);
      @(negedge clk);
      checkOutput("err set", err, 1);
      waitUntil(b + 10);
      @(negedge clk);
      checkOutput("err sticky", err, 1);
      nextCycle();
      dout_ready = 1'b1;
      applyStimulus(mkCmd(3'd6, 0, 5, 0));
      waitUntil(b + 15);
      @(negedge clk);
      checkOutput("rsvd r5 carry", dout_1, 1);
      checkOutput("rsvd r5 sum", dout_2, 2);
      nextCycle();
      dout_ready = 1'b0;
      checkNextDone("rsvd retire", b + 2);
      checkNextDone("nop after rsvd", b + 4);
      checkNextDone("read after rsvd", b + 15);

      // Narrow instance: 15-bit commands, ADD_LAT=1
      nextCycle();
      b = cyc;
      s_din_valid = 1'b1; s_din_1 = 16'hBEEF; s_din_2 = 16'h1234;
      s_dout_ready = 1'b1;
      applySmall(mkSmall(3'd1, 3, 0, 0));
      waitUntil(b + 2);
      @(negedge clk);
      checkOutput("small load early", s_ins_done, 0);
      waitUntil(b + 3);
      @(negedge clk);
      checkOutput("small load retire", s_ins_done, 1);
      waitUntil(b + 4);
      s_din_valid = 1'b0;
      applySmall(mkSmall(3'd7, 3, 0, 0));
      waitUntil(b + 6);
      @(negedge clk);
      checkOutput("small rsvd retire", s_ins_done, 1);
      waitUntil(b + 7);
      @(negedge clk);
      checkOutput("small err", s_err, 1);
      waitUntil(b + 8);
      applySmall(mkSmall(3'd2, 4, 3, 3));
      waitUntil(b + 11);
      @(negedge clk);
      checkOutput("small add retire", s_ins_done, 1);
      waitUntil(b + 12);
      applySmall(mkSmall(3'd6, 0, 3, 0));
      waitUntil(b + 16);
      @(negedge clk);
      checkOutput("small r3 carry", s_dout_1, 16'hBEEF);
      checkOutput("small r3 sum", s_dout_2, 16'h1234);
      waitUntil(b + 17);
      applySmall(mkSmall(3'd6, 0, 4, 0));
      waitUntil(b + 21);
      @(negedge clk);
      checkOutput("small r4 carry", s_dout_1, 16'h00AA);
      checkOutput("small r4 sum", s_dout_2, 16'h00BB);
      checkOutput("small err sticky", s_err, 1);
      nextCycle();
      s_dout_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/cryptoprocessor_seq.md
# cryptoprocessor_seq

Parametrised, self-sequencing successor to the fixed 89-bit carry-save cryptoprocessor. It sits between the host/command interface and the external carry-save add, sub and multiply/reduce units. A host pushes commands into an internal queue. The block then fetches each command, reads operand pairs from a two-bank (carry/sum) register file, drives the arithmetic units, waits on their latency or handshake, writes results back and streams requested values out.

## Interface
Parameters:
- W, 89, operand width of each carry and sum word
- ADDR_W, 7, register-file address width; depth is 2^ADDR_W pairs
- IQ_DEPTH, 8, command queue depth (power of two, at least 2)
- ADD_LAT, 1, fixed latency of the add/sub units in cycles (at least 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command push strobe
- cmd_ready  out  1  queue not full
- command_cp  in  3+3*ADDR_W  command: {op[2:0], dst, srcA, srcB}, op in the top 3 bits (24 bits at defaults)
- din_1, din_2  in  W  load data (carry, sum)
- din_valid  in  1  load data present
- din_ready  out  1  block accepts load data
- dout_1, dout_2  out  W  read-out data (carry, sum); forced to 0 when dout_valid is low
- dout_valid  out  1  read-out data present
- dout_ready  in  1  consumer accepts read-out data
- op_a_c, op_a_s, op_b_c, op_b_s  out  W  operand pairs, shared by all units
- add_o_c, add_o_s, sub_o_c, sub_o_s, red_o_c, red_o_s  in  W  unit results
- mul_start  out  1  one-cycle multiply launch pulse
- mul_done  in  1  one-cycle pulse; red_o_* are valid in this cycle
- busy  out  1  queue non-empty or FSM not in IDLE
- ins_done  out  1  one-cycle pulse per retired instruction
- err  out  1  sticky flag: a reserved op was executed

## Operation
- Op encoding:
  - 0 NOP
  - 1 LOAD: dst ← din
  - 2 ADD: dst ← add_o
  - 3 SUB: dst ← sub_o
  - 4 MUL: dst ← red_o
  - 5 COPY: dst ← srcA
  - 6 READ: dout ← srcA
  - 7 reserved: executes as NOP and sets err
- Register file: two banks of 2^ADDR_W × W. Two synchronous read ports (srcA, srcB) and one write port that writes carry and sum together. The register file is not reset.
- FSM states: IDLE, RD, EX, OUT.
  - IDLE: if the queue is non-empty, pop the head into the command register → RD.
  - RD: present srcA and srcB to the register file; operands are registered at the end of the cycle. NOP and reserved ops retire here → IDLE. All other ops → EX.
  - EX:
    - ADD/SUB: a down-counter loaded with ADD_LAT; at count 1, write the result and retire.
    - MUL: mul_start high in the first EX cycle only; wait for mul_done, then write red_o and retire.
    - COPY: write and retire in the first EX cycle.
    - LOAD: din_ready high; write and retire on din_valid && din_ready.
    - READ: → OUT.
  - OUT: dout_valid high with the registered srcA pair; retire on dout_ready → IDLE.
- op_a_* and op_b_* hold the registered srcA and srcB pairs, stable from the first EX cycle until retirement.
- Instructions execute strictly one at a time, so there are no data hazards; dst may equal a src.
- The queue pushes when cmd_valid && cmd_ready. A push while full is dropped, even if a pop occurs in the same cycle.
- mul_done outside a MUL EX state is ignored.

## Timing
- Reset values: cmd_ready=1, din_ready=0, dout_valid=0, dout_1/2=0, op_*=0, mul_start=0, busy=0, ins_done=0, err=0. Reset also empties the queue and sends the FSM to IDLE.
- Reset mid-instruction aborts it with no write-back and no ins_done.
- Let t be the pop cycle (IDLE):
  - NOP retires at t+1.
  - COPY retires at t+2.
  - ADD/SUB retire at t+1+ADD_LAT.
  - MUL retires in the mul_done cycle (at least t+3).
  - LOAD retires at max(t+2, first din_valid cycle).
  - READ: dout_valid rises at t+3 (OUT) and retires in the dout_ready cycle.
- The write occurs at the clock edge ending the retire cycle; ins_done is high during that cycle. The FSM is back in IDLE in the following cycle.
- A command pushed at cycle p is visible to IDLE at p+1.
- cmd_ready falls in the cycle after the push that fills the queue.

## Test plan
- Reset, then LOAD r5 with (din_1=0x1, din_2=0x2), then READ r5 → dout_1=0x1, dout_2=0x2, dout_valid held until dout_ready. READ on r3 never written is not checked.
- Ops ordered NOP, ADD, COPY with ADD_LAT=3 and add_o=(0xA,0xB) → ins_done pulses at the computed cycles, r7=(0xA,0xB), and COPY moves the ADD result to r8.
- MUL with mul_done delayed 20 cycles → mul_start is a single pulse, ins_done coincides with mul_done, and dst holds red_o. A stray mul_done while IDLE is ignored.
- Push IQ_DEPTH+1 commands back-to-back with execution stalled by a LOAD awaiting din → cmd_ready goes low after the 8th push, the 9th is dropped, and exactly 8 instructions retire.
- Assert rst during ADD EX → no write to dst, queue empty, all outputs return to reset values, and the next command executes normally.
- Op 7 → err=1 and sticky, ins_done pulses at t+1, register file unchanged. Sweep W=16 and ADDR_W=4 with a 15-bit command.
